// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: round-robin arbiter and sequencer sharing one I2C write master among NREQ requesters.
// Latency: req -> grant/m_start in 1 cycle; m_done -> done/status in 1 cycle; at least 2 idle cycles between launches.
// Backpressure: no launch while m_busy=1; requesters hold req until their done pulse. Optional single NACK retry: I2C_ARB_RETRY_EN.
module i2c_txn_arbiter #(
  parameter int NREQ    = 4,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          grant,
  output logic [NREQ-1:0]          done,
  output logic                     nack,
  output logic                     timeout,
  output logic                     busy,
  output logic                     m_start,
  output logic [ADDR_W-1:0]        m_addr,
  output logic [DATA_W-1:0]        m_data,
  input  logic                     m_busy,
  input  logic                     m_done,
  input  logic                     m_ack_ok
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  // The watchdog reads TIMEOUT-1 in the cycle that is TIMEOUT cycles after m_start.
  localparam logic [CW-1:0] WD_LAST  = CW'(TIMEOUT - 1);
  localparam logic [PW-1:0] PTR_INIT = PW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [PW-1:0]   ptr;       // last served requester; search starts just after it
  logic [PW-1:0]   owner;     // index of the current grant holder
  logic [CW-1:0]   wd;        // watchdog, cycles spent in WAIT

`ifdef I2C_ARB_RETRY_EN
  logic            attempt;   // set once the single NACK retry has been used
`endif

  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [NREQ-1:0] win_onehot;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  // Round-robin pick: first pass covers indices above ptr, second pass wraps to 0..ptr.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    win_addr   = '0;
    win_data   = '0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!win_found && req[k] && ((pass == 0) == (k > int'(ptr)))) begin
          win_found     = 1'b1;
          win_idx       = PW'(k);
          win_onehot[k] = 1'b1;
          win_addr      = req_addr[k*ADDR_W +: ADDR_W];
          win_data      = req_data[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Transaction sequencer with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      ptr     <= PTR_INIT;
      owner   <= '0;
      wd      <= '0;
      grant   <= '0;
      done    <= '0;
      nack    <= 1'b0;
      timeout <= 1'b0;
      busy    <= 1'b0;
      m_start <= 1'b0;
      m_addr  <= '0;
      m_data  <= '0;
`ifdef I2C_ARB_RETRY_EN
      attempt <= 1'b0;
`endif
    end else begin
      // Pulses default low; each state re-asserts them only where needed.
      m_start <= 1'b0;
      done    <= '0;
      case (state)
        S_IDLE: begin
`ifdef I2C_ARB_RETRY_EN
          attempt <= 1'b0;
`endif
          // Address/data are sampled here only; later requester changes are ignored.
          if (win_found && !m_busy) begin
            owner   <= win_idx;
            grant   <= win_onehot;
            m_addr  <= win_addr;
            m_data  <= win_data;
            m_start <= 1'b1;
            busy    <= 1'b1;
            state   <= S_START;
          end
        end

        S_START: begin
          wd    <= '0;
          state <= S_WAIT;
        end

        S_WAIT: begin
          wd <= wd + CW'(1);
          // A completion in the same cycle as the watchdog expiry wins.
          if (m_done) begin
`ifdef I2C_ARB_RETRY_EN
            if (!m_ack_ok && !attempt) begin
              // First NACK: relaunch the same latched transaction silently.
              attempt <= 1'b1;
              m_start <= 1'b1;
              state   <= S_START;
            end else begin
              nack    <= ~m_ack_ok;
              timeout <= 1'b0;
              done    <= grant;
              state   <= S_DONE;
            end
`else
            nack    <= ~m_ack_ok;
            timeout <= 1'b0;
            done    <= grant;
            state   <= S_DONE;
`endif
          end else if (wd == WD_LAST) begin
            nack    <= 1'b1;
            timeout <= 1'b1;
            done    <= grant;
            state   <= S_DONE;
          end
        end

        S_DONE: begin
          // done is high during this state; release ownership on exit.
          ptr   <= owner;
          grant <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
